target_layer_mem: RTL and testbench

Parametrised per-layer parameter store for the DQN target network. It replaces the fixed three-layer memory with one instance per layer, sized by `NODE_IN`/`NODE_OUT`. It supports handshaked reads and writes, address-range checking, and a hardware sync engine that copies all weight rows and biases from the policy network into the target network on request. It sits between the target-net datapath (reader), the training controller (writer) and the policy-net memory (sync source).

---
 rtl/dqn_pkg.sv | 14 +
 rtl/target_layer_mem_if.sv | 45 ++++
 rtl/dqn_row_ram.sv | 30 +++
 rtl/target_layer_mem.sv | 98 +++++++++
 tb/tb_target_layer_mem.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/dqn_pkg.sv
// dqn_pkg: network-wide widths, layer node counts and the layer-memory FSM state type.
package dqn_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int INPUT_NODES = 2;
    localparam int HIDDEN_1_NODES = 32;
    localparam int HIDDEN_2_NODES = 32;
    localparam int OUTPUT_NODES = 3;

    typedef enum logic [1:0] {IDLE, SYNC, DONE} mem_state_t;

    function automatic int weight_row_width(input int node_in, input int data_width);
        return data_width * node_in;
    endfunction
endpackage

// File: rtl/target_layer_mem_if.sv
// target_layer_mem_if: read, write and policy-sync handshakes of one target-network layer memory.
interface target_layer_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NODE_IN = 2,
    parameter int NODE_OUT = 32,
    parameter int ADDR_WIDTH = NODE_OUT > 1 ? $clog2(NODE_OUT) : 1
) ();
    logic                           i_rd_req;
    logic [ADDR_WIDTH-1:0]          i_rd_addr;
    logic                           o_rd_ready;
    logic [DATA_WIDTH-1:0]          o_data;
    logic [DATA_WIDTH*NODE_IN-1:0]  o_weight;
    logic [DATA_WIDTH-1:0]          o_bias;
    logic                           o_valid;
    logic                           o_addr_err;
    logic                           i_wr_valid;
    logic                           i_wr_mode;
    logic [ADDR_WIDTH-1:0]          i_wr_addr;
    logic [DATA_WIDTH-1:0]          i_data;
    logic [DATA_WIDTH*NODE_IN-1:0]  i_weight;
    logic [DATA_WIDTH-1:0]          i_bias;
    logic                           o_wr_ready;
    logic                           i_sync_start;
    logic                           o_src_req;
    logic [ADDR_WIDTH-1:0]          o_src_addr;
    logic                           i_src_valid;
    logic [DATA_WIDTH*NODE_IN-1:0]  i_src_weight;
    logic [DATA_WIDTH-1:0]          i_src_bias;
    logic                           o_sync_busy;
    logic                           o_sync_done;

    modport slave (
        input  i_rd_req, i_rd_addr, i_wr_valid, i_wr_mode, i_wr_addr, i_data, i_weight, i_bias,
               i_sync_start, i_src_valid, i_src_weight, i_src_bias,
        output o_rd_ready, o_data, o_weight, o_bias, o_valid, o_addr_err, o_wr_ready,
               o_src_req, o_src_addr, o_sync_busy, o_sync_done
    );

    modport master (
        output i_rd_req, i_rd_addr, i_wr_valid, i_wr_mode, i_wr_addr, i_data, i_weight, i_bias,
               i_sync_start, i_src_valid, i_src_weight, i_src_bias,
        input  o_rd_ready, o_data, o_weight, o_bias, o_valid, o_addr_err, o_wr_ready,
               o_src_req, o_src_addr, o_sync_busy, o_sync_done
    );
endinterface

// File: rtl/dqn_row_ram.sv
// dqn_row_ram: row array with one write port, a registered read port and reset clear.
module dqn_row_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    localparam logic [AW:0] LIM = (AW+1)'(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    // Out-of-range rows read as zero and swallow writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rdata_q <= '0;
        end else begin
            if (we_i && {1'b0, waddr_i} < LIM) mem_q[waddr_i] <= wdata_i;
            if (re_i) rdata_q <= ({1'b0, raddr_i} < LIM) ? mem_q[raddr_i] : '0;
        end
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/target_layer_mem.sv
// target_layer_mem: per-layer target-network store with handshaked access and policy sync engine.
module target_layer_mem #(
    parameter int DATA_WIDTH = dqn_pkg::DATA_WIDTH,
    parameter int NODE_IN = 2,
    parameter int NODE_OUT = 32,
    parameter int ADDR_WIDTH = NODE_OUT > 1 ? $clog2(NODE_OUT) : 1
) (
    input logic clk,
    input logic rst_n,
    target_layer_mem_if.slave bus
);
    import dqn_pkg::*;
    localparam int RW = weight_row_width(NODE_IN, DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH+1)'(NODE_OUT);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NODE_OUT - 1);

    mem_state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] k_q, k_d, src_addr_q, wb_addr;
    logic src_req_q, busy_q, valid_q, err_q;
    logic ready, rd_acc, wr_acc, rd_oor, wr_oor, sync_wr, wb_we;
    logic [RW-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] b_wdata;

    // Sync start wins over a same-cycle read/write by dropping ready combinationally.
    assign ready   = state_q == IDLE && !bus.i_sync_start;
    assign rd_acc  = bus.i_rd_req && ready;
    assign wr_acc  = bus.i_wr_valid && ready;
    assign rd_oor  = {1'b0, bus.i_rd_addr} >= LIM;
    assign wr_oor  = {1'b0, bus.i_wr_addr} >= LIM;
    assign sync_wr = state_q == SYNC && bus.i_src_valid;
    assign wb_we   = sync_wr || (wr_acc && bus.i_wr_mode);
    assign wb_addr = sync_wr ? k_q : bus.i_wr_addr;
    assign w_wdata = sync_wr ? bus.i_src_weight : bus.i_weight;
    assign b_wdata = sync_wr ? bus.i_src_bias : bus.i_bias;

    always_comb begin
        state_d = state_q;
        k_d = k_q;
        case (state_q)
            IDLE: if (bus.i_sync_start) begin
                state_d = SYNC;
                k_d = '0;
            end
            SYNC: if (bus.i_src_valid) begin
                state_d = k_q == LAST ? DONE : SYNC;
                k_d = k_q == LAST ? '0 : k_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q <= '0;
            src_req_q <= 1'b0;
            src_addr_q <= '0;
            busy_q <= 1'b0;
            valid_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            src_req_q <= state_d == SYNC;
            src_addr_q <= k_d;
            busy_q <= state_d != IDLE;
            valid_q <= rd_acc;
            err_q <= (rd_acc && rd_oor) || (wr_acc && wr_oor);
        end
    end

    dqn_row_ram #(.WIDTH(DATA_WIDTH), .DEPTH(NODE_OUT), .AW(ADDR_WIDTH)) u_data (
        .clk(clk), .rst_n(rst_n),
        .we_i(wr_acc && !bus.i_wr_mode), .waddr_i(bus.i_wr_addr), .wdata_i(bus.i_data),
        .re_i(rd_acc), .raddr_i(bus.i_rd_addr), .rdata_o(bus.o_data)
    );

    dqn_row_ram #(.WIDTH(RW), .DEPTH(NODE_OUT), .AW(ADDR_WIDTH)) u_weight (
        .clk(clk), .rst_n(rst_n),
        .we_i(wb_we), .waddr_i(wb_addr), .wdata_i(w_wdata),
        .re_i(rd_acc), .raddr_i(bus.i_rd_addr), .rdata_o(bus.o_weight)
    );

    dqn_row_ram #(.WIDTH(DATA_WIDTH), .DEPTH(NODE_OUT), .AW(ADDR_WIDTH)) u_bias (
        .clk(clk), .rst_n(rst_n),
        .we_i(wb_we), .waddr_i(wb_addr), .wdata_i(b_wdata),
        .re_i(rd_acc), .raddr_i(bus.i_rd_addr), .rdata_o(bus.o_bias)
    );

    assign bus.o_rd_ready  = ready;
    assign bus.o_wr_ready  = ready;
    assign bus.o_valid     = valid_q;
    assign bus.o_addr_err  = err_q;
    assign bus.o_src_req   = src_req_q;
    assign bus.o_src_addr  = src_addr_q;
    assign bus.o_sync_busy = busy_q;
    assign bus.o_sync_done = state_q == DONE;
endmodule

// File: tb/tb_target_layer_mem.sv
// tb_target_layer_mem: directed checks of reads, writes, range errors and policy sync on a 3-row layer.
module tb_target_layer_mem;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int passed = 0;
    int total = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    target_layer_mem_if #(.DATA_WIDTH(32), .NODE_IN(2), .NODE_OUT(3)) bus ();

    target_layer_mem #(.DATA_WIDTH(32), .NODE_IN(2), .NODE_OUT(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    always @(negedge clk) if (bus.o_sync_done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.i_rd_req = 0; bus.i_rd_addr = 0;
        bus.i_wr_valid = 0; bus.i_wr_mode = 0; bus.i_wr_addr = 0;
        bus.i_data = 0; bus.i_weight = 0; bus.i_bias = 0;
        bus.i_sync_start = 0; bus.i_src_valid = 0; bus.i_src_weight = 0; bus.i_src_bias = 0;
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({bus.o_valid, bus.o_addr_err, bus.o_src_req, bus.o_sync_busy, bus.o_sync_done} !== 5'b0)
            $display("FAIL reset_flags got=%b exp=00000", {bus.o_valid, bus.o_addr_err, bus.o_src_req, bus.o_sync_busy, bus.o_sync_done}); else passed++;
        total++; if ({bus.o_data, bus.o_weight, bus.o_bias, bus.o_src_addr} !== '0)
            $display("FAIL reset_data got=%h exp=0", {bus.o_data, bus.o_weight, bus.o_bias, bus.o_src_addr}); else passed++;
        total++; if ({bus.o_rd_ready, bus.o_wr_ready} !== 2'b11)
            $display("FAIL reset_ready got=%b exp=11", {bus.o_rd_ready, bus.o_wr_ready}); else passed++;
        rst_n = 1;
        tick();
        bus.i_rd_req = 1; bus.i_rd_addr = 2;
        tick();
        clear_in();
        total++; if ({bus.o_valid, bus.o_addr_err} !== 2'b10)
            $display("FAIL reset_read_flags got=%b exp=10", {bus.o_valid, bus.o_addr_err}); else passed++;
        total++; if ({bus.o_data, bus.o_weight, bus.o_bias} !== '0)
            $display("FAIL reset_read_data got=%h exp=0", {bus.o_data, bus.o_weight, bus.o_bias}); else passed++;
        tick();
        total++; if (bus.o_valid !== 1'b0)
            $display("FAIL valid_pulse got=%b exp=0", bus.o_valid); else passed++;
    endtask

    task automatic test_write_mode1();
        bus.i_wr_valid = 1; bus.i_wr_mode = 1; bus.i_wr_addr = 1;
        bus.i_weight = 64'h3F800000_40000000; bus.i_bias = 32'hBF800000;
        tick();
        clear_in();
        bus.i_rd_req = 1; bus.i_rd_addr = 1;
        tick();
        clear_in();
        total++; if (bus.o_weight !== 64'h3F800000_40000000)
            $display("FAIL mode1_weight got=%h exp=3f80000040000000", bus.o_weight); else passed++;
        total++; if (bus.o_bias !== 32'hBF800000)
            $display("FAIL mode1_bias got=%h exp=bf800000", bus.o_bias); else passed++;
        total++; if ({bus.o_valid, bus.o_addr_err, bus.o_data} !== {2'b10, 32'h0})
            $display("FAIL mode1_data got=%b/%h exp=10/0", {bus.o_valid, bus.o_addr_err}, bus.o_data); else passed++;
    endtask

    task automatic test_read_before_write();
        bus.i_rd_req = 1; bus.i_rd_addr = 0;
        bus.i_wr_valid = 1; bus.i_wr_mode = 0; bus.i_wr_addr = 0; bus.i_data = 32'h12345678;
        tick();
        clear_in();
        total++; if ({bus.o_valid, bus.o_data} !== {1'b1, 32'h0})
            $display("FAIL rbw_old got=%b/%h exp=1/0", bus.o_valid, bus.o_data); else passed++;
        bus.i_rd_req = 1; bus.i_rd_addr = 0;
        tick();
        clear_in();
        total++; if (bus.o_data !== 32'h12345678)
            $display("FAIL rbw_new got=%h exp=12345678", bus.o_data); else passed++;
    endtask

    task automatic test_addr_range();
        bus.i_wr_valid = 1; bus.i_wr_mode = 0; bus.i_wr_addr = 3; bus.i_data = 32'hDEADBEEF;
        tick();
        clear_in();
        total++; if ({bus.o_addr_err, bus.o_valid} !== 2'b10)
            $display("FAIL oor_wr_err got=%b exp=10", {bus.o_addr_err, bus.o_valid}); else passed++;
        tick();
        total++; if (bus.o_addr_err !== 1'b0)
            $display("FAIL oor_err_pulse got=%b exp=0", bus.o_addr_err); else passed++;
        bus.i_rd_req = 1; bus.i_rd_addr = 3;
        tick();
        clear_in();
        total++; if ({bus.o_valid, bus.o_addr_err} !== 2'b11)
            $display("FAIL oor_rd_flags got=%b exp=11", {bus.o_valid, bus.o_addr_err}); else passed++;
        total++; if ({bus.o_data, bus.o_weight, bus.o_bias} !== '0)
            $display("FAIL oor_rd_data got=%h exp=0", {bus.o_data, bus.o_weight, bus.o_bias}); else passed++;
        bus.i_rd_req = 1; bus.i_rd_addr = 0;
        tick();
        clear_in();
        total++; if ({bus.o_addr_err, bus.o_data} !== {1'b0, 32'h12345678})
            $display("FAIL oor_no_alias got=%b/%h exp=0/12345678", bus.o_addr_err, bus.o_data); else passed++;
    endtask

    task automatic test_sync();
        logic [31:0] exp_data [3];
        exp_data[0] = 32'h12345678; exp_data[1] = 32'h0; exp_data[2] = 32'h0;
        done_cnt = 0;
        bus.i_sync_start = 1;
        bus.i_rd_req = 1; bus.i_rd_addr = 0;
        bus.i_wr_valid = 1; bus.i_wr_mode = 0; bus.i_wr_addr = 2; bus.i_data = 32'hAAAA5555;
        #1;
        total++; if ({bus.o_rd_ready, bus.o_wr_ready} !== 2'b00)
            $display("FAIL sync_prio_ready got=%b exp=00", {bus.o_rd_ready, bus.o_wr_ready}); else passed++;
        tick();
        clear_in();
        total++; if ({bus.o_valid, bus.o_sync_busy, bus.o_src_req} !== 3'b011)
            $display("FAIL sync_enter got=%b exp=011", {bus.o_valid, bus.o_sync_busy, bus.o_src_req}); else passed++;
        for (int r = 0; r < 3; r++) begin
            repeat (2) begin
                total++; if ({bus.o_src_req, bus.o_src_addr, bus.o_sync_done} !== {1'b1, 2'(r), 1'b0})
                    $display("FAIL sync_stall row=%0d got=%b/%0d/%b exp=1/%0d/0", r, bus.o_src_req, bus.o_src_addr, bus.o_sync_done, r); else passed++;
                tick();
            end
            bus.i_src_valid = 1; bus.i_src_weight = 64'(r + 1); bus.i_src_bias = 32'(16 * (r + 1));
            tick();
            clear_in();
        end
        total++; if ({bus.o_sync_done, bus.o_sync_busy, bus.o_src_req, bus.o_rd_ready} !== 4'b1100)
            $display("FAIL sync_done_state got=%b exp=1100", {bus.o_sync_done, bus.o_sync_busy, bus.o_src_req, bus.o_rd_ready}); else passed++;
        bus.i_src_valid = 1; bus.i_src_weight = 64'hFF; bus.i_src_bias = 32'hFF;
        tick();
        total++; if ({bus.o_sync_done, bus.o_sync_busy, bus.o_rd_ready, bus.o_wr_ready} !== 4'b0011)
            $display("FAIL sync_idle got=%b exp=0011", {bus.o_sync_done, bus.o_sync_busy, bus.o_rd_ready, bus.o_wr_ready}); else passed++;
        total++; if (done_cnt !== 1)
            $display("FAIL sync_done_count got=%0d exp=1", done_cnt); else passed++;
        for (int r = 0; r < 3; r++) begin
            bus.i_rd_req = 1; bus.i_rd_addr = 2'(r);
            tick();
            total++; if ({bus.o_weight, bus.o_bias, bus.o_data} !== {64'(r + 1), 32'(16 * (r + 1)), exp_data[r]})
                $display("FAIL sync_readback row=%0d got=%h/%h/%h exp=%h/%h/%h", r, bus.o_weight, bus.o_bias, bus.o_data,
                         64'(r + 1), 32'(16 * (r + 1)), exp_data[r]); else passed++;
        end
        clear_in();
    endtask

    task automatic test_reset_during_sync();
        bus.i_sync_start = 1;
        tick();
        clear_in();
        bus.i_src_valid = 1; bus.i_src_weight = 64'h7; bus.i_src_bias = 32'h7;
        tick();
        tick();
        clear_in();
        done_cnt = 0;
        total++; if ({bus.o_sync_busy, bus.o_src_addr} !== {1'b1, 2'd2})
            $display("FAIL rst_sync_pre got=%b/%0d exp=1/2", bus.o_sync_busy, bus.o_src_addr); else passed++;
        rst_n = 0;
        #1;
        total++; if ({bus.o_src_req, bus.o_sync_busy, bus.o_sync_done, bus.o_valid, bus.o_addr_err} !== 5'b0)
            $display("FAIL rst_sync_flags got=%b exp=00000", {bus.o_src_req, bus.o_sync_busy, bus.o_sync_done, bus.o_valid, bus.o_addr_err}); else passed++;
        total++; if ({bus.o_weight, bus.o_bias, bus.o_src_addr, bus.o_rd_ready} !== {98'h0, 1'b1})
            $display("FAIL rst_sync_outs got=%h/%h/%0d/%b exp=0/0/0/1", bus.o_weight, bus.o_bias, bus.o_src_addr, bus.o_rd_ready); else passed++;
        repeat (2) tick();
        rst_n = 1;
        repeat (2) tick();
        for (int r = 0; r < 3; r++) begin
            bus.i_rd_req = 1; bus.i_rd_addr = 2'(r);
            tick();
            total++; if ({bus.o_valid, bus.o_data, bus.o_weight, bus.o_bias} !== {1'b1, 128'h0})
                $display("FAIL rst_sync_clear row=%0d got=%b/%h/%h/%h exp=1/0/0/0", r, bus.o_valid, bus.o_data, bus.o_weight, bus.o_bias); else passed++;
        end
        clear_in();
        tick();
        total++; if (done_cnt !== 0)
            $display("FAIL rst_sync_no_done got=%0d exp=0", done_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_write_mode1();
        test_read_before_write();
        test_addr_range();
        test_sync();
        test_reset_during_sync();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
